// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives operands; the slave returns status and the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             START;
    logic             B0;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BOUT;

    modport master (
        output START, B0, X, Y,
        input  BUSY, DONE, D, BOUT
    );

    modport slave (
        input  START, B0, X, Y,
        output BUSY, DONE, D, BOUT
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one difference bit per cycle, LSB first.
// Result and borrow-out are visible, with DONE, in the FIN cycle.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    serial_subtractor_if.slave  bus
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             dbit;
    logic             nbr;
    logic             last;

    // One full-subtractor cell on the current LSBs of the shifting operands.
    always_comb begin
        dbit = x_q[0] ^ y_q[0] ^ br_q;
        nbr  = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & br_q);
        last = (idx_q == IW'(WIDTH - 1));
    end

    // Next-state logic; D/BOUT are loaded on entry to FIN so they show with DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        diff_d  = diff_q;
        d_d     = d_q;
        idx_d   = idx_q;
        br_d    = br_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    x_d     = bus.X;
                    y_d     = bus.Y;
                    br_d    = bus.B0;
                    idx_d   = '0;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d    = x_q >> 1;
                y_d    = y_q >> 1;
                br_d   = nbr;
                diff_d = {dbit, diff_q[WIDTH-1:1]};
                idx_d  = idx_q + IW'(1);
                if (last) begin
                    d_d     = {dbit, diff_q[WIDTH-1:1]};
                    bout_d  = nbr;
                    idx_d   = '0;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            diff_q  <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            diff_q  <= diff_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.BUSY = (state_q == RUN);
    assign bus.DONE = (state_q == FIN);
    assign bus.D    = d_q;
    assign bus.BOUT = bout_q;
endmodule
